// File: rtl/synapse_pkg.sv
// Shared types and width helpers for the synapse MAC slice.
package synapse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_N_CH     = 4;
  localparam int DEF_OUT_W    = 8;

  // Wide enough that a full vector of maximum products can never wrap.
  function automatic int acc_width(input int data_w, input int weight_w, input int n_ch);
    return data_w + weight_w + $clog2(n_ch);
  endfunction

endpackage

// File: rtl/synapse_weight_rf.sv
// Per-channel weight register file: synchronous write, combinational indexed read.
module synapse_weight_rf
  import synapse_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int WEIGHT_W = DEF_WEIGHT_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we,
  input  logic [$clog2(N_CH)-1:0] waddr,
  input  logic [WEIGHT_W-1:0]     wdata,
  input  logic [$clog2(N_CH)-1:0] raddr,
  output logic [WEIGHT_W-1:0]     rdata
);

  logic [WEIGHT_W-1:0] w_q [N_CH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CH; i++) begin
        w_q[i] <= '0;
      end
    end else if (we) begin
      w_q[waddr] <= wdata;
    end
  end

  // A read in the write cycle sees the previous weight.
  assign rdata = w_q[raddr];

endmodule

// File: rtl/synapse_mac.sv
// Multi-channel synapse: sequential unsigned MAC over an N_CH input vector.
// SYNAPSE_MAC_SAT_EN selects clamping of the sum instead of legacy truncation.
module synapse_mac
  import synapse_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int N_CH     = DEF_N_CH,
  parameter int OUT_W    = DEF_OUT_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     w_we_i,
  input  logic [$clog2(N_CH)-1:0]  w_addr_i,
  input  logic [WEIGHT_W-1:0]      w_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [N_CH*DATA_W-1:0]   in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [OUT_W-1:0]         out_data_o,
  output logic                     out_sat_o
);

  localparam int IDX_W  = $clog2(N_CH);
  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int ACC_W  = acc_width(DATA_W, WEIGHT_W, N_CH);

  state_t                   state_q, state_d;
  logic [N_CH*DATA_W-1:0]   sample_q;
  logic [IDX_W-1:0]         idx_q;
  logic [ACC_W-1:0]         acc_q;
  logic [ACC_W-1:0]         acc_nxt;
  logic [DATA_W-1:0]        sample_sel;
  logic [WEIGHT_W-1:0]      weight_sel;
  logic [PROD_W-1:0]        prod;
  logic                     last_ch;
  logic [OUT_W-1:0]         out_data_q;
  logic                     out_sat_q;

  function automatic logic over_range(input logic [ACC_W-1:0] a);
    return (a >> OUT_W) != '0;
  endfunction

  function automatic logic [OUT_W-1:0] reduce_out(input logic [ACC_W-1:0] a);
`ifdef SYNAPSE_MAC_SAT_EN
    if (over_range(a)) begin
      return {OUT_W{1'b1}};
    end
    return OUT_W'(a);
`else
    return OUT_W'(a);
`endif
  endfunction

  synapse_weight_rf #(
    .N_CH     (N_CH),
    .WEIGHT_W (WEIGHT_W)
  ) u_weight_rf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (w_we_i),
    .waddr (w_addr_i),
    .wdata (w_data_i),
    .raddr (idx_q),
    .rdata (weight_sel)
  );

  assign last_ch    = (idx_q == IDX_W'(N_CH - 1));
  assign sample_sel = sample_q[idx_q*DATA_W +: DATA_W];
  assign prod       = PROD_W'(sample_sel) * PROD_W'(weight_sel);
  assign acc_nxt    = acc_q + ACC_W'(prod);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i)  state_d = ACCUM;
      ACCUM:   if (last_ch)     state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  // Capture at the handshake, accumulate one channel per cycle, latch the result on the last channel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_q   <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            sample_q <= in_data_i;
            idx_q    <= '0;
            acc_q    <= '0;
          end
        end
        ACCUM: begin
          acc_q <= acc_nxt;
          idx_q <= idx_q + IDX_W'(1);
          if (last_ch) begin
            out_data_q <= reduce_out(acc_nxt);
            out_sat_q  <= over_range(acc_nxt);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data_o = out_data_q;
  assign out_sat_o  = out_sat_q;

endmodule

// File: tb/tb_synapse_mac.sv
// Directed bench for synapse_mac with hand-computed sums (default widths, N_CH=4).
module tb_synapse_mac;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        w_we_i;
  logic [1:0]  w_addr_i;
  logic [7:0]  w_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  out_data_o;
  logic        out_sat_o;

  int tests = 0;
  int fails = 0;

  synapse_mac dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .w_we_i      (w_we_i),
    .w_addr_i    (w_addr_i),
    .w_data_i    (w_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_sat_o   (out_sat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] c0, input logic [7:0] c1,
                                        input logic [7:0] c2, input logic [7:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic write_w(input logic [1:0] ch, input logic [7:0] val);
    @(negedge clk_i);
    w_we_i = 1'b1; w_addr_i = ch; w_data_i = val;
    @(negedge clk_i);
    w_we_i = 1'b0;
  endtask

  task automatic load_w(input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] w3);
    write_w(2'd0, w0);
    write_w(2'd1, w1);
    write_w(2'd2, w2);
    write_w(2'd3, w3);
  endtask

  // Handshake, then count cycles to out_valid_o; optional writes mid-vector.
  task automatic send_vec(input logic [31:0] data, input bit mw, output int lat);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!in_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    in_valid_i = 1'b1; in_data_i = data;
    @(negedge clk_i);
    in_valid_i = 1'b0; in_data_i = '0;
    lat = 1;
    while (!out_valid_o && lat < 50) begin
      if (mw && lat == 2) begin w_we_i = 1'b1; w_addr_i = 2'd3; w_data_i = 8'd10; end
      if (mw && lat == 3) begin w_we_i = 1'b1; w_addr_i = 2'd0; w_data_i = 8'd10; end
      if (mw && lat == 4) w_we_i = 1'b0;
      @(negedge clk_i);
      lat++;
    end
    w_we_i = 1'b0;
  endtask

  task automatic accept_out();
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check("in_ready_after_accept", in_ready_o, 1);
    check("out_valid_after_accept", out_valid_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] held;
`ifdef SYNAPSE_MAC_SAT_EN
    logic [7:0] big_exp = 8'd255;
`else
    logic [7:0] big_exp = 8'd4;
`endif
    rst_i = 1'b1; w_we_i = 1'b0; w_addr_i = '0; w_data_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_data", out_data_o, 0);
    check("rst_out_sat", out_sat_o, 0);

    // Basic: weights {1,2,3,4}, data 10 each -> 100
    load_w(8'd1, 8'd2, 8'd3, 8'd4);
    send_vec(pack4(8'd10, 8'd10, 8'd10, 8'd10), 1'b0, lat);
    check("basic_latency", lat, 5);
    check("basic_data", out_data_o, 100);
    check("basic_sat", out_sat_o, 0);
    accept_out();

    // Backpressure: 20 each -> 200, held while a second vector is offered
    send_vec(pack4(8'd20, 8'd20, 8'd20, 8'd20), 1'b0, lat);
    check("bp_data", out_data_o, 200);
    held = out_data_o;
    in_valid_i = 1'b1; in_data_i = pack4(8'd1, 8'd1, 8'd1, 8'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("bp_hold_valid", out_valid_o, 1);
      check("bp_hold_data", out_data_o, 200);
      check("bp_hold_ready", in_ready_o, 0);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check("bp_ready_after_pulse", in_ready_o, 1);
    @(negedge clk_i);
    in_valid_i = 1'b0; in_data_i = '0;
    check("bp_second_accepted", in_ready_o, 0);
    lat = 1;
    while (!out_valid_o && lat < 50) begin
      @(negedge clk_i);
      lat++;
    end
    check("bp_second_latency", lat, 5);
    check("bp_second_data", out_data_o, 10);
    accept_out();

    // Overflow: 255*255*4 = 260100
    load_w(8'd255, 8'd255, 8'd255, 8'd255);
    send_vec(pack4(8'd255, 8'd255, 8'd255, 8'd255), 1'b0, lat);
    check("big_data", out_data_o, big_exp);
    check("big_sat", out_sat_o, 1);
    accept_out();

    // Mid-vector weight writes: ch3 reached later uses new, ch0 already used keeps old
    load_w(8'd1, 8'd1, 8'd1, 8'd1);
    send_vec(pack4(8'd1, 8'd2, 8'd3, 8'd4), 1'b1, lat);
    check("mw_latency", lat, 5);
    check("mw_data", out_data_o, 46);
    accept_out();
    send_vec(pack4(8'd1, 8'd2, 8'd3, 8'd4), 1'b0, lat);
    check("mw_next_data", out_data_o, 55);
    accept_out();

    // Reset mid-ACCUM drops the vector and clears the weights
    @(negedge clk_i);
    in_valid_i = 1'b1; in_data_i = pack4(8'd9, 8'd9, 8'd9, 8'd9);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_out_valid", out_valid_o, 0);
    check("midrst_in_ready", in_ready_o, 1);
    repeat (6) @(negedge clk_i);
    check("midrst_no_output", out_valid_o, 0);
    send_vec(pack4(8'd10, 8'd20, 8'd30, 8'd40), 1'b0, lat);
    check("midrst_zero_data", out_data_o, 0);
    accept_out();
    send_vec(pack4(8'd200, 8'd200, 8'd200, 8'd200), 1'b0, lat);
    check("zero_w_data", out_data_o, 0);
    check("zero_w_sat", out_sat_o, 0);
    accept_out();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/synapse_mac.md
# synapse_mac

Parametrised multi-channel successor to the single-channel synapse. It holds a writable per-channel weight register file and accepts one input vector of N_CH samples per valid/ready handshake. It multiply-accumulates the vector sequentially, one channel per cycle, and delivers a single width-limited weighted sum to the downstream neuron. It sits between the input spike/data fabric and the neuron membrane-update block.

## Interface
- DATA_W, 8, unsigned input sample width
- WEIGHT_W, 8, unsigned weight width
- N_CH, 4, channel count (≥2)
- OUT_W, 8, output sum width
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- w_we_i  in  1  weight write enable
- w_addr_i  in  $clog2(N_CH)  weight channel index
- w_data_i  in  WEIGHT_W  weight value
- in_valid_i  in  1  input vector valid
- in_ready_o  out  1  block can accept a vector
- in_data_i  in  N_CH*DATA_W  packed samples, channel 0 in LSBs
- out_valid_o  out  1  weighted sum valid
- out_ready_i  in  1  downstream accepts sum
- out_data_o  out  OUT_W  weighted sum
- out_sat_o  out  1  sum exceeded OUT_W range

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: in_ready_o=1. On in_valid_i&in_ready_o, capture in_data_i into the sample register, clear the accumulator and channel index, then go to ACCUM.
- ACCUM: each cycle, acc += sample[idx]*weight[idx] and idx++. The cycle that adds idx==N_CH-1 registers the final result and goes to DONE.
- DONE: out_valid_o=1. out_data_o and out_sat_o are held stable. On out_ready_i, go to IDLE.
- Arithmetic is unsigned. The accumulator is DATA_W+WEIGHT_W+$clog2(N_CH) bits and never wraps.
- Output reduction (see Configuration): out_sat_o=1 iff acc ≥ 2^OUT_W.
- Weight writes are accepted in any state and take effect the following cycle.
  - A write in the same cycle ACCUM reads that channel: the old weight is used.
  - A write to a channel not yet reached in the current vector: the new weight is used.
- in_valid_i is ignored unless in state IDLE. in_data_i is sampled only at the handshake.
- Reset values: state IDLE, in_ready_o=1, out_valid_o=0, out_data_o=0, out_sat_o=0, all weights 0, accumulator 0, idx 0.
- Reset in any state, including mid-ACCUM or DONE, discards the vector in flight. No output is produced for it.

## Timing
- Handshake in cycle T leads to ACCUM during cycles T+1..T+N_CH, with out_valid_o first high in cycle T+N_CH+1.
- If out_ready_i=1 in that cycle, in_ready_o is high again in T+N_CH+2. Peak throughput is one vector per N_CH+2 cycles.
- Backpressure: out_valid_o stays high and outputs stay unchanged until out_ready_i; in_ready_o stays 0 meanwhile.
- No combinational path from any input to any output. All outputs are registered or decoded from the state register.

## Configuration
- SYNAPSE_MAC_SAT_EN defined: out_data_o = min(acc, 2^OUT_W-1); out_sat_o reports the clamp.
- SYNAPSE_MAC_SAT_EN undefined: out_data_o = acc[OUT_W-1:0] (legacy truncation); out_sat_o is still computed but informational only.

## Structure
- synapse_pkg holds:
  - the FSM state enum (IDLE, ACCUM, DONE);
  - an accumulator-width function of DATA_W, WEIGHT_W and N_CH;
  - the shared default-width constants.
- Sub-module synapse_weight_rf: N_CH×WEIGHT_W registers, synchronous write, combinational read by index, synchronous reset to 0.
- The MAC datapath and FSM stay in synapse_mac.

## Test plan
- Defaults; weights {1,2,3,4}, data {10,10,10,10}, handshake at T → out_valid_o at T+5, out_data_o=100, out_sat_o=0.
- Weights all 255, data all 255 (sum 260100):
  - with SYNAPSE_MAC_SAT_EN → out_data_o=255, out_sat_o=1;
  - without → out_data_o=4, out_sat_o=1.
- Hold out_ready_i=0 for 3 cycles after out_valid_o while driving in_valid_i=1 → out_data_o stable, in_ready_o=0, second vector accepted only after the out_ready_i pulse.
- Assert rst_i at T+2 mid-ACCUM → next cycle out_valid_o=0, in_ready_o=1; a vector sent with no weight writes yields out_data_o=0.
- Weights {1,1,1,1}, data {1,2,3,4}; write ch3=10 at T+2 and ch0=10 at T+3 → result 1+2+3+40=46. The next identical vector yields 10+2+3+40=55.
- Reset with no weight loads, data {200,200,200,200} → out_data_o=0, out_sat_o=0.
